digit_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed digit-enable scanner for the clock's multi-digit seven-segment display. Generalises the fixed 2-to-4 select decoder with these additions:
- internal refresh prescaler and digit-index counter;
- anti-ghosting blank interval at each digit change;
- per-digit blanking mask;
- selectable enable polarity.

It drives the digit-enable pins. It exports the current digit index so the segment-data mux stays aligned.

---
 rtl/digit_scan_pkg.sv | 15 +
 rtl/onehot_dec_msb.sv | 19 +
 rtl/digit_scan_ctrl.sv | 106 ++++++++++
 tb/tb_digit_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared definitions for the seven-segment digit scanner: state encoding and index-width helper.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  // Index width: clog2(n), but never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_dec_msb.sv
// Combinational index to MSB-first one-hot decoder: index i drives bit N-1-i.
module onehot_dec_msb
  import digit_scan_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [IW-1:0] idx_i,
  output logic [N-1:0]  onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_i == IW'(k)) onehot_c[N-1-k] = 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit-enable scanner with refresh prescaler, anti-ghost blanking,
// per-digit dark mask and selectable enable polarity.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS    = 4,
  parameter  int unsigned PRESCALE      = 100000,
  parameter  int unsigned BLANK_CYCLES  = 16,
  parameter  bit          EN_ACTIVE_LOW = 1'b0,
  localparam int unsigned IDX_W         = idx_w(NUM_DIGITS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic [NUM_DIGITS-1:0] blank_mask_i,
  output logic [IDX_W-1:0]      sct_o,
  output logic [NUM_DIGITS-1:0] en_o,
  output logic                  slot_start_o
);

  localparam int unsigned           CNT_W      = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = {NUM_DIGITS{EN_ACTIVE_LOW}};
  localparam scan_state_e           SLOT_ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  slot_start_q, slot_start_d;
  logic [NUM_DIGITS-1:0] dec_onehot_c;

  // Decode the next index so the registered enable lines up with the registered index.
  onehot_dec_msb #(.N(NUM_DIGITS)) u_dec (
    .idx_i    (idx_d),
    .onehot_c (dec_onehot_c)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      en_q         <= EN_OFF;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      en_q         <= en_d;
      slot_start_q <= slot_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    slot_start_d = 1'b0;
    en_d         = EN_OFF;

    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d      = SLOT_ENTRY;
          cnt_d        = '0;
          idx_d        = '0;
          slot_start_d = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d      = SLOT_ENTRY;
            cnt_d        = '0;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            slot_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Mask is sampled at the same edge that loads the enable, hence one cycle of latency.
    if (state_d == DRIVE && !blank_mask_i[idx_d]) en_d = dec_onehot_c ^ EN_OFF;
  end

  assign sct_o        = idx_q;
  assign en_o         = en_q;
  assign slot_start_o = slot_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: two configurations against a slot-arithmetic model.
module tb_digit_scan_ctrl;

  localparam int A_N = 4, A_P = 8, A_B = 2;
  localparam int B_N = 3, B_P = 5, B_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n = 1'b1, enable_a = 1'b0;
  logic [3:0] mask_a = '0, dig_a;
  logic [1:0] sct_a;
  logic       ss_a;

  logic       rst_b_n = 1'b1, enable_b = 1'b0;
  logic [2:0] mask_b = '0, dig_b;
  logic [1:0] sct_b;
  logic       ss_b;

  int checks = 0;
  int errors = 0;

  digit_scan_ctrl #(.NUM_DIGITS(A_N), .PRESCALE(A_P), .BLANK_CYCLES(A_B), .EN_ACTIVE_LOW(1'b0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a_n), .enable_i(enable_a), .blank_mask_i(mask_a),
    .sct_o(sct_a), .en_o(dig_a), .slot_start_o(ss_a)
  );

  digit_scan_ctrl #(.NUM_DIGITS(B_N), .PRESCALE(B_P), .BLANK_CYCLES(B_B), .EN_ACTIVE_LOW(1'b1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b_n), .enable_i(enable_b), .blank_mask_i(mask_b),
    .sct_o(sct_b), .en_o(dig_b), .slot_start_o(ss_b)
  );

  // Reference model: cycles elapsed since the enabling edge, plus the mask seen at the last edge.
  bit         run_a = 1'b0, run_b = 1'b0;
  int         t_a = 0, t_b = 0;
  logic [7:0] m_a = '0, m_b = '0;

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      run_a <= 1'b0; t_a <= 0; m_a <= '0;
    end else begin
      m_a   <= 8'(mask_a);
      run_a <= enable_a;
      t_a   <= (enable_a && run_a) ? t_a + 1 : 0;
    end
  end

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      run_b <= 1'b0; t_b <= 0; m_b <= '0;
    end else begin
      m_b   <= 8'(mask_b);
      run_b <= enable_b;
      t_b   <= (enable_b && run_b) ? t_b + 1 : 0;
    end
  end

  function automatic logic [7:0] exp_en(bit run, int t, logic [7:0] m, int n, int p, int b, bit low);
    logic [7:0] r;
    int idx, pos;
    r = '0;
    if (run) begin
      pos = t % p;
      idx = (t / p) % n;
      if (pos >= b && !m[idx]) r[n-1-idx] = 1'b1;
    end
    if (low) r = ~r & 8'((1 << n) - 1);
    return r;
  endfunction

  function automatic int exp_idx(bit run, int t, int n, int p);
    return run ? (t / p) % n : 0;
  endfunction

  function automatic logic exp_ss(bit run, int t, int p);
    return run && (t % p == 0);
  endfunction

  task automatic test_reset();
    #1;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    #11;
    checks += 6;
    if (dig_a !== 4'b0000) begin errors++; $display("FAIL reset_en_a got %b exp 0000", dig_a); end
    if (sct_a !== 2'd0)    begin errors++; $display("FAIL reset_sct_a got %0d exp 0", sct_a); end
    if (ss_a !== 1'b0)     begin errors++; $display("FAIL reset_ss_a got %b exp 0", ss_a); end
    if (dig_b !== 3'b111)  begin errors++; $display("FAIL reset_en_b got %b exp 111", dig_b); end
    if (sct_b !== 2'd0)    begin errors++; $display("FAIL reset_sct_b got %0d exp 0", sct_b); end
    if (ss_b !== 1'b0)     begin errors++; $display("FAIL reset_ss_b got %b exp 0", ss_b); end
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
  endtask

  task automatic run_check_a(input string tag, input int cycles);
    logic [7:0] e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      e = exp_en(run_a, t_a, m_a, A_N, A_P, A_B, 1'b0);
      checks += 3;
      if (dig_a !== e[3:0]) begin errors++; $display("FAIL %s_en t=%0d got %b exp %b", tag, t_a, dig_a, e[3:0]); end
      if (sct_a !== 2'(exp_idx(run_a, t_a, A_N, A_P)))
        begin errors++; $display("FAIL %s_sct t=%0d got %0d exp %0d", tag, t_a, sct_a, exp_idx(run_a, t_a, A_N, A_P)); end
      if (ss_a !== exp_ss(run_a, t_a, A_P))
        begin errors++; $display("FAIL %s_ss t=%0d got %b exp %b", tag, t_a, ss_a, exp_ss(run_a, t_a, A_P)); end
    end
  endtask

  task automatic test_scan();
    @(negedge clk);
    enable_a = 1'b1; mask_a = '0;
    run_check_a("scan", 70);
  endtask

  task automatic wait_a(input string tag, input int idx, input int pos, output bit found);
    found = 1'b0;
    for (int i = 0; i < 4 * A_N * A_P && !found; i++) begin
      @(negedge clk);
      found = run_a && ((t_a / A_P) % A_N == idx) && (t_a % A_P == pos);
    end
    if (!found) begin checks++; errors++; $display("FAIL %s_wait timed out got no slot %0d pos %0d", tag, idx, pos); end
  endtask

  task automatic test_mask();
    bit found;
    mask_a = 4'b0100;
    run_check_a("mask", 40);
    mask_a = 4'b0000;
    wait_a("mask_mid", 1, 4, found);
    if (found) begin
      checks++;
      if (dig_a !== 4'b0100) begin errors++; $display("FAIL mask_mid_pre got %b exp 0100", dig_a); end
      mask_a = 4'b0010;
      @(negedge clk);
      checks++;
      if (dig_a !== 4'b0000) begin errors++; $display("FAIL mask_mid_dark got %b exp 0000", dig_a); end
    end
    mask_a = 4'b0000;
    run_check_a("mask_clear", 12);
  endtask

  task automatic test_enable_drop();
    bit found;
    wait_a("drop", 2, 4, found);
    if (found) begin
      enable_a = 1'b0;
      @(negedge clk);
      checks += 3;
      if (dig_a !== 4'b0000) begin errors++; $display("FAIL drop_en got %b exp 0000", dig_a); end
      if (sct_a !== 2'd0)    begin errors++; $display("FAIL drop_sct got %0d exp 0", sct_a); end
      if (ss_a !== 1'b0)     begin errors++; $display("FAIL drop_ss got %b exp 0", ss_a); end
      enable_a = 1'b1;
      @(negedge clk);
      checks += 3;
      if (ss_a !== 1'b1)     begin errors++; $display("FAIL reen_ss got %b exp 1", ss_a); end
      if (sct_a !== 2'd0)    begin errors++; $display("FAIL reen_sct got %0d exp 0", sct_a); end
      if (dig_a !== 4'b0000) begin errors++; $display("FAIL reen_blank0 got %b exp 0000", dig_a); end
      @(negedge clk);
      checks += 2;
      if (dig_a !== 4'b0000) begin errors++; $display("FAIL reen_blank1 got %b exp 0000", dig_a); end
      if (ss_a !== 1'b0)     begin errors++; $display("FAIL reen_ss_low got %b exp 0", ss_a); end
      @(negedge clk);
      checks++;
      if (dig_a !== 4'b1000) begin errors++; $display("FAIL reen_drive got %b exp 1000", dig_a); end
    end
    run_check_a("drop_after", 20);
  endtask

  task automatic test_reset_mid();
    bit found;
    wait_a("rstmid", 1, 1, found);
    if (found) begin
      #2 rst_a_n = 1'b0;
      #1;
      checks += 3;
      if (dig_a !== 4'b0000) begin errors++; $display("FAIL rstmid_en got %b exp 0000", dig_a); end
      if (sct_a !== 2'd0)    begin errors++; $display("FAIL rstmid_sct got %0d exp 0", sct_a); end
      if (ss_a !== 1'b0)     begin errors++; $display("FAIL rstmid_ss got %b exp 0", ss_a); end
      @(negedge clk);
      rst_a_n = 1'b1;
    end
    run_check_a("rstmid_after", 40);
  endtask

  task automatic test_polarity();
    logic [7:0] e;
    @(negedge clk);
    enable_b = 1'b1; mask_b = '0;
    @(negedge clk);
    checks++;
    if (dig_b !== 3'b011) begin errors++; $display("FAIL pol_first got %b exp 011", dig_b); end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_en(run_b, t_b, m_b, B_N, B_P, B_B, 1'b1);
      checks += 3;
      if (dig_b !== e[2:0]) begin errors++; $display("FAIL pol_en t=%0d got %b exp %b", t_b, dig_b, e[2:0]); end
      if (sct_b !== 2'(exp_idx(run_b, t_b, B_N, B_P)))
        begin errors++; $display("FAIL pol_sct t=%0d got %0d exp %0d", t_b, sct_b, exp_idx(run_b, t_b, B_N, B_P)); end
      if (ss_b !== exp_ss(run_b, t_b, B_P))
        begin errors++; $display("FAIL pol_ss t=%0d got %b exp %b", t_b, ss_b, exp_ss(run_b, t_b, B_P)); end
    end
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    int  len_a = 0, len_b = 0;
    bit  have_a = 1'b0, have_b = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ea = exp_en(run_a, t_a, m_a, A_N, A_P, A_B, 1'b0);
      eb = exp_en(run_b, t_b, m_b, B_N, B_P, B_B, 1'b1);
      checks += 8;
      if (dig_a !== ea[3:0]) begin errors++; $display("FAIL rnd_en_a t=%0d got %b exp %b", t_a, dig_a, ea[3:0]); end
      if (dig_b !== eb[2:0]) begin errors++; $display("FAIL rnd_en_b t=%0d got %b exp %b", t_b, dig_b, eb[2:0]); end
      if (sct_a !== 2'(exp_idx(run_a, t_a, A_N, A_P)))
        begin errors++; $display("FAIL rnd_sct_a t=%0d got %0d exp %0d", t_a, sct_a, exp_idx(run_a, t_a, A_N, A_P)); end
      if (sct_b !== 2'(exp_idx(run_b, t_b, B_N, B_P)))
        begin errors++; $display("FAIL rnd_sct_b t=%0d got %0d exp %0d", t_b, sct_b, exp_idx(run_b, t_b, B_N, B_P)); end
      if (ss_a !== exp_ss(run_a, t_a, A_P)) begin errors++; $display("FAIL rnd_ss_a t=%0d got %b", t_a, ss_a); end
      if (ss_b !== exp_ss(run_b, t_b, B_P)) begin errors++; $display("FAIL rnd_ss_b t=%0d got %b", t_b, ss_b); end
      if ($countones(dig_a) > 1 || $countones(~dig_b) > 1)
        begin errors++; $display("FAIL rnd_onehot got a=%b b=%b exp at most one active", dig_a, dig_b); end
      if (int'(sct_b) >= B_N) begin errors++; $display("FAIL rnd_sct_range got %0d exp < %0d", sct_b, B_N); end

      // Slot length measured between consecutive slot_start pulses of one continuous run.
      if (!run_a) have_a = 1'b0;
      else if (ss_a) begin
        if (have_a) begin
          checks++;
          if (len_a != A_P) begin errors++; $display("FAIL rnd_slot_len_a got %0d exp %0d", len_a, A_P); end
        end
        have_a = 1'b1; len_a = 1;
      end else len_a++;
      if (!run_b) have_b = 1'b0;
      else if (ss_b) begin
        if (have_b) begin
          checks++;
          if (len_b != B_P) begin errors++; $display("FAIL rnd_slot_len_b got %0d exp %0d", len_b, B_P); end
        end
        have_b = 1'b1; len_b = 1;
      end else len_b++;

      if ($urandom_range(0, 39) == 0) enable_a = ~enable_a;
      if ($urandom_range(0, 39) == 0) enable_b = ~enable_b;
      if ($urandom_range(0, 9) == 0)  mask_a = 4'($urandom);
      if ($urandom_range(0, 9) == 0)  mask_b = 3'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mask();
    test_enable_drop();
    test_reset_mid();
    test_polarity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
